// File: rtl/debounce_sync_if.sv
// debounce_sync_if: raw input and conditioned outputs of the debouncer.
interface debounce_sync_if;
   logic a;
   logic y;
   logic busy;
   logic rise;
   logic fall;
   modport master (output a, input y, busy, rise, fall);
   modport slave (input a, output y, busy, rise, fall);
endinterface

// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchroniser plus stability filter; edge pulses built only with DEBOUNCE_EDGE_EN.
module debounce_sync #(
   parameter int STABLE_CYCLES = 1000,
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic rst,
   debounce_sync_if.slave io
);
   typedef enum logic [1:0] {LOW, CHK_H, HIGH, CHK_L} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   state_t state;
   logic s1, s2, y_q, busy_q;
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         state <= LOW;
         cnt <= '0;
         y_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         s1 <= io.a;
         s2 <= s1;
         case (state)
            LOW: if (s2) begin
               state <= CHK_H;
               cnt <= '0;
               busy_q <= 1'b1;
            end
            CHK_H: if (!s2) begin
               state <= LOW;
               cnt <= '0;
               busy_q <= 1'b0;
            end else if (cnt == LAST) begin
               state <= HIGH;
               cnt <= '0;
               y_q <= 1'b1;
               busy_q <= 1'b0;
            end else cnt <= cnt + CNT_W'(1);
            HIGH: if (!s2) begin
               state <= CHK_L;
               cnt <= '0;
               busy_q <= 1'b1;
            end
            CHK_L: if (s2) begin
               state <= HIGH;
               cnt <= '0;
               busy_q <= 1'b0;
            end else if (cnt == LAST) begin
               state <= LOW;
               cnt <= '0;
               y_q <= 1'b0;
               busy_q <= 1'b0;
            end else cnt <= cnt + CNT_W'(1);
            default: state <= LOW;
         endcase
      end
   end
   assign io.y = y_q;
   assign io.busy = busy_q;
`ifdef DEBOUNCE_EDGE_EN
   logic rise_q, fall_q;
   // Pulses register on the same edge that commits y, so they line up with the new level.
   always_ff @(posedge clk) begin
      rise_q <= !rst && state == CHK_H && s2 && cnt == LAST;
      fall_q <= !rst && state == CHK_L && !s2 && cnt == LAST;
   end
   assign io.rise = rise_q;
   assign io.fall = fall_q;
`else
   assign io.rise = 1'b0;
   assign io.fall = 1'b0;
`endif
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed plus random stimulus against a run-length model of the debouncer.
module tb_debounce_sync;
   localparam int STABLE = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   debounce_sync_if bus ();
   debounce_sync #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (.clk(clk), .rst(rst), .io(bus));
   always #5 clk = ~clk;
`ifdef DEBOUNCE_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif
   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask
   // Model: y flips once the synchronised input has disagreed with y for STABLE+1 sampled edges in a row.
   logic p1 = 1'b0, p2 = 1'b0, my = 1'b0, mr = 1'b0, mf = 1'b0;
   int run = 0;
   initial forever begin
      @(posedge clk);
      if (rst) begin
         p1 = 1'b0;
         p2 = 1'b0;
         my = 1'b0;
         mr = 1'b0;
         mf = 1'b0;
         run = 0;
      end else begin
         mr = 1'b0;
         mf = 1'b0;
         run = (p2 != my) ? run + 1 : 0;
         if (run == STABLE + 1) begin
            my = p2;
            mr = p2;
            mf = !p2;
            run = 0;
         end
         p2 = p1;
         p1 = bus.a;
      end
      #1;
      chk("model_y", bus.y, my);
      chk("model_busy", bus.busy, run != 0);
      chk("model_rise", bus.rise, EDGE & mr);
      chk("model_fall", bus.fall, EDGE & mf);
   end
   task automatic cyc(input logic av, input logic rv);
      @(negedge clk);
      bus.a = av;
      rst = rv;
      @(posedge clk);
      #2;
   endtask
   initial begin
      bus.a = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b1);
         chk("rst_y", bus.y, 1'b0);
         chk("rst_busy", bus.busy, 1'b0);
         chk("rst_rise", bus.rise, 1'b0);
         chk("rst_fall", bus.fall, 1'b0);
      end
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 1'b0);
         chk("rel_y", bus.y, i >= 7);
         chk("rel_rise", bus.rise, EDGE && i == 7);
      end
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 1'b0);
         chk("fall_y", bus.y, i < 7);
         chk("fall_pulse", bus.fall, EDGE && i == 7);
      end
      repeat (4) cyc(1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 1'b0);
         chk("step_busy", bus.busy, i >= 3 && i <= 6);
         chk("step_y", bus.y, i >= 7);
      end
      repeat (10) cyc(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cyc(i % 2 == 0, 1'b0);
         chk("bounce_y", bus.y, 1'b0);
      end
      repeat (10) cyc(1'b1, 1'b0);
      chk("bounce_settled", bus.y, 1'b1);
      repeat (12) cyc(1'b0, 1'b0);
      repeat (5) cyc(1'b1, 1'b0);
      repeat (12) cyc(1'b0, 1'b0);
      repeat (4) cyc(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 1'b0);
         chk("near4_y", bus.y, 1'b0);
      end
      repeat (4) cyc(1'b1, 1'b0);
      chk("mid_busy", bus.busy, 1'b1);
      cyc(1'b1, 1'b1);
      chk("mid_rst_y", bus.y, 1'b0);
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_rise", bus.rise, 1'b0);
      repeat (4) cyc(1'b0, 1'b0);
      for (int n = 0; n < 300; n++) begin
         logic v;
         int len;
         v = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 9);
         repeat (len) cyc(v, $urandom_range(0, 199) == 0);
      end
      cyc(1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
